// File: rtl/comp_share_arbiter_pkg.sv
// comp_pkg: shared constants and state encoding for the compare-sharing arbiter
package comp_pkg;

    localparam int WIDTH_DEF = 4;
    localparam int CNT_W_DEF = 8;

    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_COMPARE = 2'd1;
    localparam logic [1:0] S_RESP    = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE    = S_IDLE,
        ST_COMPARE = S_COMPARE,
        ST_RESP    = S_RESP
    } state_t;

endpackage

// File: rtl/comp_share_arbiter_eq_compare.sv
// eq_compare: combinational WIDTH-bit equality comparator
module eq_compare #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             equal
);

    assign equal = (a == b);

endmodule

// File: rtl/comp_share_arbiter.sv
// comp_share_arbiter: round-robin sharing of one equality comparator between two requesters
module comp_share_arbiter
    import comp_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req0_valid,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    output logic             req1_ready,
    output logic             resp0_valid,
    output logic             resp1_valid,
    output logic             resp_equal,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] match_cnt,
    output logic [CNT_W-1:0] cmp_cnt,
    output logic             busy
);

    state_t           state;
    logic             last_grant;
    logic             owner;
    logic             grant_sel;
    logic             equal;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;

    // round-robin pick: a lone requester wins, a tie goes to the one not served last
    always_comb grant_sel = (req0_valid && req1_valid) ? ~last_grant : req1_valid;

    assign req0_ready = (state == ST_IDLE) && !grant_sel && req0_valid;
    assign req1_ready = (state == ST_IDLE) &&  grant_sel && req1_valid;
    assign busy       = (state != ST_IDLE);

    eq_compare #(.WIDTH(WIDTH)) u_eq (
        .a     (a_q),
        .b     (b_q),
        .equal (equal)
    );

    // sequencer: accept in IDLE, compare for one cycle, pulse the owner's response for one cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            last_grant  <= 1'b1;
            owner       <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            resp0_valid <= 1'b0;
            resp1_valid <= 1'b0;
            resp_equal  <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req0_ready || req1_ready) begin
                        a_q        <= grant_sel ? req1_a : req0_a;
                        b_q        <= grant_sel ? req1_b : req0_b;
                        owner      <= grant_sel;
                        last_grant <= grant_sel;
                        state      <= ST_COMPARE;
                    end
                end
                ST_COMPARE: begin
                    resp_equal  <= equal;
                    resp0_valid <= !owner;
                    resp1_valid <= owner;
                    state       <= ST_RESP;
                end
                ST_RESP: begin
                    resp0_valid <= 1'b0;
                    resp1_valid <= 1'b0;
                    state       <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // status counters: bump on the response cycle, clear takes priority
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            match_cnt <= '0;
            cmp_cnt   <= '0;
        end else if (clr_cnt) begin
            match_cnt <= '0;
            cmp_cnt   <= '0;
        end else if (state == ST_RESP) begin
            cmp_cnt <= cmp_cnt + 1'b1;
            if (resp_equal && match_cnt != '1) match_cnt <= match_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_comp_share_arbiter.sv
// tb_comp_share_arbiter: scenario tasks plus randomized traffic against a transaction-level model
module tb_comp_share_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req0_valid = 1'b0, req1_valid = 1'b0, clr_cnt = 1'b0;
    logic [3:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
    logic       req0_ready, req1_ready, resp0_valid, resp1_valid, resp_equal, busy;
    logic [7:0] match_cnt, cmp_cnt;

    int errors = 0;
    int checks = 0;

    // model: one pending transaction described by the cycle its response is due
    int cyc = 0, resp_at = -10, m_match = 0, m_cmp = 0;
    bit m_owner = 0, m_eq = 0, m_last = 1;

    bit e_rdy0, e_rdy1, e_resp0, e_resp1, e_eq, e_busy;
    int e_match, e_cmp;
    logic o_rdy0, o_rdy1, o_resp0, o_resp1, o_eq, o_busy;
    logic [7:0] o_match, o_cmp;

    comp_share_arbiter #(.WIDTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_a(req0_a), .req0_b(req0_b), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_a(req1_a), .req1_b(req1_b), .req1_ready(req1_ready),
        .resp0_valid(resp0_valid), .resp1_valid(resp1_valid), .resp_equal(resp_equal),
        .clr_cnt(clr_cnt), .match_cnt(match_cnt), .cmp_cnt(cmp_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        resp_at = -10; m_last = 1; m_match = 0; m_cmp = 0; m_owner = 0; m_eq = 0;
    endtask

    // one clock cycle: drive, predict, sample at negedge, then advance the model at posedge
    task automatic tick(input bit v0, input logic [3:0] a0, input logic [3:0] b0,
                        input bit v1, input logic [3:0] a1, input logic [3:0] b1, input bit clr);
        bit idle;
        req0_valid = v0; req0_a = a0; req0_b = b0;
        req1_valid = v1; req1_a = a1; req1_b = b1;
        clr_cnt = clr;
        idle    = cyc > resp_at;
        e_rdy0  = idle && v0 && (!v1 || m_last);
        e_rdy1  = idle && v1 && (!v0 || !m_last);
        e_resp0 = (cyc == resp_at) && !m_owner;
        e_resp1 = (cyc == resp_at) && m_owner;
        e_eq    = m_eq;
        e_busy  = !idle;
        e_match = m_match;
        e_cmp   = m_cmp;
        @(negedge clk);
        o_rdy0 = req0_ready; o_rdy1 = req1_ready; o_resp0 = resp0_valid; o_resp1 = resp1_valid;
        o_eq = resp_equal; o_busy = busy; o_match = match_cnt; o_cmp = cmp_cnt;
        @(posedge clk);
        if (cyc == resp_at) begin
            m_cmp = (m_cmp + 1) % 256;
            if (m_eq && m_match < 255) m_match++;
        end
        if (clr) begin m_cmp = 0; m_match = 0; end
        if (e_rdy0 || e_rdy1) begin
            m_owner = e_rdy1;
            m_eq    = e_rdy1 ? (a1 == b1) : (a0 == b0);
            m_last  = e_rdy1;
            resp_at = cyc + 2;
        end
        cyc++;
        #1;
    endtask

    task automatic idle_tick();
        tick(0, 4'd0, 4'd0, 0, 4'd0, 4'd0, 0);
    endtask

    task automatic do_reset();
        req0_valid = 0; req1_valid = 0; clr_cnt = 0;
        rst_n = 0;
        @(posedge clk); #1;
        model_reset();
        rst_n = 1;
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if ({req0_ready, req1_ready, resp0_valid, resp1_valid, resp_equal, busy, match_cnt, cmp_cnt} !== 22'd0)
            begin errors++; $display("FAIL reset_outputs got=%b exp=0", {req0_ready, req1_ready, resp0_valid, resp1_valid, resp_equal, busy, match_cnt, cmp_cnt}); end
        @(posedge clk); #1;
        rst_n = 1;
        model_reset();
    endtask

    task automatic test_single();
        tick(1, 4'b1010, 4'b1010, 0, 4'd0, 4'd0, 0);
        checks++; if (o_rdy0 !== 1'b1 || o_rdy1 !== 1'b0) begin errors++; $display("FAIL single_ready got=%b%b exp=10", o_rdy0, o_rdy1); end
        idle_tick();
        checks++; if (o_busy !== 1'b1 || o_resp0 !== 1'b0) begin errors++; $display("FAIL single_compare busy=%b resp0=%b exp busy=1 resp0=0", o_busy, o_resp0); end
        idle_tick();
        checks++; if (o_resp0 !== 1'b1 || o_eq !== 1'b1 || o_resp1 !== 1'b0) begin errors++; $display("FAIL single_resp got=%b%b%b exp=110", o_resp0, o_eq, o_resp1); end
        idle_tick();
        checks++; if (o_match !== 8'd1 || o_cmp !== 8'd1 || o_busy !== 1'b0 || o_resp0 !== 1'b0) begin errors++; $display("FAIL single_counters match=%0d cmp=%0d busy=%b exp 1 1 0", o_match, o_cmp, o_busy); end
    endtask

    task automatic test_mismatch();
        tick(0, 4'd0, 4'd0, 1, 4'b1111, 4'b0000, 0);
        checks++; if (o_rdy1 !== 1'b1 || o_rdy0 !== 1'b0) begin errors++; $display("FAIL mismatch_ready got=%b%b exp=01", o_rdy0, o_rdy1); end
        idle_tick();
        idle_tick();
        checks++; if (o_resp1 !== 1'b1 || o_eq !== 1'b0 || o_resp0 !== 1'b0) begin errors++; $display("FAIL mismatch_resp got resp1=%b eq=%b resp0=%b exp 1 0 0", o_resp1, o_eq, o_resp0); end
        idle_tick();
        checks++; if (o_match !== 8'd1 || o_cmp !== 8'd2) begin errors++; $display("FAIL mismatch_counters match=%0d cmp=%0d exp 1 2", o_match, o_cmp); end
    endtask

    task automatic test_contention();
        int gq[$];
        int gc[$];
        do_reset();
        for (int i = 0; i < 12; i++) begin
            tick(1, 4'b0001, 4'b0001, 1, 4'b1100, 4'b1010, 0);
            if (o_rdy0 || o_rdy1) begin gq.push_back(int'(o_rdy1)); gc.push_back(i); end
            checks++; if (o_rdy0 && o_rdy1) begin errors++; $display("FAIL contention_both_ready cyc=%0d", i); end
            if (o_resp0 || o_resp1) begin
                checks++; if (o_eq !== o_resp0) begin errors++; $display("FAIL contention_eq cyc=%0d got=%b exp=%b", i, o_eq, o_resp0); end
            end
        end
        checks++;
        if (gq.size() != 4) begin errors++; $display("FAIL contention_grants got=%0d exp=4", gq.size()); end
        else for (int k = 0; k < 4; k++) begin
            checks++;
            if (gq[k] != k % 2 || gc[k] != 3 * k) begin errors++; $display("FAIL contention_order k=%0d got=%0d@%0d exp=%0d@%0d", k, gq[k], gc[k], k % 2, 3 * k); end
        end
        idle_tick();
        checks++; if (o_cmp !== 8'd4 || o_match !== 8'd2) begin errors++; $display("FAIL contention_counters cmp=%0d match=%0d exp 4 2", o_cmp, o_match); end
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 0; i < 768; i++) tick(1, 4'b0101, 4'b0101, 0, 4'd0, 4'd0, 0);
        idle_tick();
        checks++; if (o_match !== 8'd255 || o_cmp !== 8'd0) begin errors++; $display("FAIL saturation match=%0d cmp=%0d exp 255 0", o_match, o_cmp); end
    endtask

    task automatic test_clear();
        tick(0, 4'd0, 4'd0, 1, 4'b0011, 4'b0011, 0);
        idle_tick();
        tick(0, 4'd0, 4'd0, 0, 4'd0, 4'd0, 1);
        checks++; if (o_resp1 !== 1'b1) begin errors++; $display("FAIL clear_in_resp resp1=%b exp=1", o_resp1); end
        idle_tick();
        checks++; if (o_match !== 8'd0 || o_cmp !== 8'd0) begin errors++; $display("FAIL clear_counters match=%0d cmp=%0d exp 0 0", o_match, o_cmp); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        tick(1, 4'b0110, 4'b0110, 0, 4'd0, 4'd0, 0);
        req0_valid = 0;
        rst_n = 0;
        #2;
        checks++;
        if ({resp0_valid, resp1_valid, resp_equal, busy, match_cnt, cmp_cnt} !== 20'd0)
            begin errors++; $display("FAIL reset_mid_outputs got=%b exp=0", {resp0_valid, resp1_valid, resp_equal, busy, match_cnt, cmp_cnt}); end
        @(posedge clk); #1;
        model_reset();
        rst_n = 1;
        for (int i = 0; i < 4; i++) begin
            idle_tick();
            checks++; if (o_resp0 || o_resp1 || o_busy) begin errors++; $display("FAIL reset_mid_quiet cyc=%0d resp=%b%b busy=%b exp 000", i, o_resp0, o_resp1, o_busy); end
        end
        tick(1, 4'b0001, 4'b0010, 1, 4'b0011, 4'b0011, 0);
        checks++; if (o_rdy0 !== 1'b1 || o_rdy1 !== 1'b0) begin errors++; $display("FAIL reset_mid_priority got=%b%b exp=10", o_rdy0, o_rdy1); end
        idle_tick();
        idle_tick();
    endtask

    task automatic test_withdraw();
        logic [7:0] cmp0;
        do_reset();
        tick(1, 4'b1001, 4'b1001, 0, 4'd0, 4'd0, 0);
        tick(0, 4'd0, 4'd0, 1, 4'b0111, 4'b0111, 0);
        checks++; if (o_rdy1 !== 1'b0) begin errors++; $display("FAIL withdraw_ready_busy got=%b exp=0", o_rdy1); end
        cmp0 = o_cmp;
        for (int i = 0; i < 4; i++) begin
            idle_tick();
            checks++; if (o_rdy1 || o_resp1) begin errors++; $display("FAIL withdraw_no_txn cyc=%0d rdy1=%b resp1=%b exp 0 0", i, o_rdy1, o_resp1); end
        end
        checks++; if (o_cmp !== cmp0 + 8'd1) begin errors++; $display("FAIL withdraw_counters cmp=%0d exp=%0d", o_cmp, cmp0 + 8'd1); end
    endtask

    task automatic test_random();
        logic [3:0] a0, b0, a1, b1;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            a0 = 4'($urandom); a1 = 4'($urandom);
            b0 = $urandom_range(0, 1) ? a0 : 4'($urandom);
            b1 = $urandom_range(0, 1) ? a1 : 4'($urandom);
            tick(bit'($urandom_range(0, 2) != 0), a0, b0, bit'($urandom_range(0, 2) != 0), a1, b1, bit'($urandom_range(0, 15) == 0));
            checks++;
            if ({o_rdy0, o_rdy1, o_resp0, o_resp1, o_busy} !== {e_rdy0, e_rdy1, e_resp0, e_resp1, e_busy})
                begin errors++; $display("FAIL random_ctrl cyc=%0d got=%b exp=%b", i, {o_rdy0, o_rdy1, o_resp0, o_resp1, o_busy}, {e_rdy0, e_rdy1, e_resp0, e_resp1, e_busy}); end
            checks++;
            if (o_match !== 8'(e_match) || o_cmp !== 8'(e_cmp))
                begin errors++; $display("FAIL random_cnt cyc=%0d got=%0d/%0d exp=%0d/%0d", i, o_match, o_cmp, e_match, e_cmp); end
            if (e_resp0 || e_resp1) begin
                checks++; if (o_eq !== e_eq) begin errors++; $display("FAIL random_eq cyc=%0d got=%b exp=%b", i, o_eq, e_eq); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_mismatch();
        test_contention();
        test_saturation();
        test_clear();
        test_reset_mid();
        test_withdraw();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
